// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard; state updates on the falling clock edge.
// Latency: reads are combinational, with an optional same-cycle write forward; busy_cnt is registered.
// Backpressure: none; every write and set_en is accepted on each falling edge when the index is valid.
module reg_file_sb #(
    parameter int  XLEN     = 64,
    parameter int  NREGS    = 32,
    parameter int  NRD      = 2,
    parameter int  ZERO_REG = 1,
    parameter int  BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;
    logic [AW-1:0]    ra [NRD];
    logic             wr_ok;
    logic             set_ok;
    logic             fwd_en;

    // Out-of-range indices and the hardwired zero register never hold state.
    function automatic logic idx_ok(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !(ZERO_REG != 0 && a == '0);
    endfunction

    assign wr_ok  = we && idx_ok(waddr);
    assign set_ok = set_en && idx_ok(set_addr);
    assign fwd_en = (BYPASS != 0) && rst_n && wr_ok;

    // The write clears busy first so a same-index set ends up winning.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[waddr] = 1'b0;
        end
        if (set_ok) begin
            busy_nxt[set_addr] = 1'b1;
        end
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            ra[i] = raddr[i*AW +: AW];
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (idx_ok(ra[i])) begin
                if (fwd_en && (waddr == ra[i])) begin
                    rdata[i*XLEN +: XLEN] = wdata;
                    rbusy[i]              = set_ok && (set_addr == ra[i]);
                end else begin
                    rdata[i*XLEN +: XLEN] = regs[ra[i]];
                    rbusy[i]              = busy[ra[i]];
                end
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok) begin
                regs[waddr] <= wdata;
            end
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 64, data width of each register in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers; AW = $clog2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter ZERO_REG, default 1; when 1, register 0 reads as zero and is never written or marked busy.
REQ-005 Parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to matching read ports.
REQ-006 Port clk  input  1  clock; all state updates occur on the falling edge.
REQ-007 Port rst_n  input  1  asynchronous reset, active low.
REQ-008 Port we  input  1  write enable for the write port.
REQ-009 Port waddr  input  AW  write register index.
REQ-010 Port wdata  input  XLEN  write data.
REQ-011 Port set_en  input  1  mark register set_addr busy (pending producer issued).
REQ-012 Port set_addr  input  AW  register index to mark busy.
REQ-013 Port raddr  input  NRD*AW  packed read indices; port i occupies bits [i*AW +: AW].
REQ-014 Port rdata  output  NRD*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
REQ-015 Port rbusy  output  NRD  per-port busy flag for raddr[i].
REQ-016 Port busy_cnt  output  AW+1  number of registers currently marked busy.

Function
REQ-017 Storage SHALL be NREGS x XLEN registers plus an NREGS-bit busy vector.
REQ-018 On the falling edge of clk, when we=1, reg[waddr] SHALL load wdata.
REQ-019 On the falling edge of clk, when we=1, busy[waddr] SHALL clear.
REQ-020 On the falling edge of clk, when set_en=1, busy[set_addr] SHALL set.
REQ-021 When set_en=1 and we=1 with set_addr==waddr in the same cycle, the data SHALL be written and busy SHALL end set (set wins).
REQ-022 With ZERO_REG=1, writes and set_en targeting index 0 SHALL be ignored, and rdata/rbusy for index 0 SHALL be 0.
REQ-023 Writes or set_en to an index >= NREGS (non-power-of-2 NREGS) SHALL be ignored; reads of such an index SHALL return 0 and rbusy 0.
REQ-024 rdata[i] SHALL be combinational: reg[raddr[i]], zero-latency.
REQ-025 With BYPASS=1, when we=1 and waddr==raddr[i] (and the index is valid and not zero-gated), rdata[i] SHALL equal wdata and rbusy[i] SHALL be 0, unless set_en targets the same index, in which case rbusy[i]=1.
REQ-026 With BYPASS=0, rdata[i]/rbusy[i] SHALL reflect stored state only, updated after the falling edge.
REQ-027 Multiple read ports addressing the same index SHALL return identical values.
REQ-028 busy_cnt SHALL be a registered popcount of the busy vector, updated on the same falling edge as busy, never exceeding NREGS - ZERO_REG.
REQ-029 set_en on an already-busy register SHALL leave it busy with no count change; we on a non-busy register SHALL leave busy_cnt unchanged.

Reset
REQ-030 When rst_n falls, all registers, the busy vector and busy_cnt SHALL clear to 0 immediately, independent of clk.
REQ-031 While rst_n=0, we and set_en SHALL have no effect; rdata SHALL read 0 and rbusy 0 (bypass disabled).
REQ-032 After rst_n rises, the first falling clk edge SHALL be the first to accept writes or set_en.
REQ-033 Reset asserted mid-cycle with we=1 SHALL discard that write.

Verification
REQ-034 Reset, then we=1 waddr=5 wdata=0xDEAD_BEEF, raddr[0]=5 same cycle -> rdata[0]=0xDEAD_BEEF combinationally (BYPASS=1); after the edge, it persists with we=0.
REQ-035 we=1 waddr=0 wdata=0x1234 -> rdata for raddr=0 stays 0; set_en addr 0 -> busy_cnt stays 0.
REQ-036 set_en addr 7 -> rbusy=1 for raddr=7, busy_cnt=1; then we addr 7 -> rbusy=0, busy_cnt=0.
REQ-037 set_en=1 and we=1 both addr 9, wdata=0x55 -> reg[9]=0x55, busy[9]=1, busy_cnt increments by 1.
REQ-038 Fill regs 1..31 with index value, assert rst_n=0 between clk edges -> all rdata=0 and busy_cnt=0 immediately; a write attempted during reset is absent after release.
REQ-039 BYPASS=0 build: we addr 3 wdata=0xAA, raddr=3 -> old value before the falling edge, 0xAA after it.
